uart_msg_serializer: RTL
========================

// Module: uart_msg_serializer
// PURPOSE
//   Sends one 2^MSG_LOG_WIDTH-byte message over a UART TX line as 8N1 frames.
//   It is the send-side counterpart of the multibyte UART receiver.
//   Sits between the dsha_finisher result path and RsTx.
//   Uses a ready/req handshake, so no result is dropped while a message is in flight.
// PARAMETERS
//   CLK_CYCLES     87  clock cycles per UART bit (115200 baud @ 10 MHz); must be >= 2
//   MSG_LOG_WIDTH  6   log2 of message length in bytes (6 -> 64 bytes, 512 bits)
// PORTS
//   clk      in   1                      system clock (10 MHz)
//   rst_n    in   1                      asynchronous, active-low reset
//   data     in   8*2**MSG_LOG_WIDTH     message; byte i = data[8*i+7:8*i]
//   req      in   1                      request to send data
//   ready    out  1                      block idle; req is accepted this cycle
//   done     out  1                      1-cycle pulse after the last stop bit
//   uart_tx  out  1                      serial line, idle high, registered
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - ready=1, done=0, uart_tx=1, state IDLE, all counters 0.
//     - Asserting reset mid-message aborts the message; uart_tx goes to 1 immediately.
//   Accept:
//     - At a rising edge with ready&req=1, data is latched into a shadow register.
//     - At that same edge: state->START, ready->0, uart_tx->0.
//     - While ready=0, data and req are ignored.
//   Frame per byte, bits LSB first; every bit is held exactly CLK_CYCLES cycles:
//     - START bit: uart_tx=0.
//     - DATA: 8 bits; uart_tx=shadow[8*byte_idx+bit_idx].
//     - STOP bit: uart_tx=1.
//   Byte order: byte 0 first, through byte 2^MSG_LOG_WIDTH-1.
//   States: IDLE -> START -> DATA -> STOP -> (START if more bytes, else IDLE)
//   Counters:
//     - baud_cnt counts 0..CLK_CYCLES-1; it wraps to 0 on every bit boundary.
//     - bit_idx is 3 bits; byte_idx is MSG_LOG_WIDTH bits.
//     - byte_idx wraps to 0 after the last byte; that wrap ends the message.
//   End of message:
//     - At the edge that ends the last STOP bit: state->IDLE, ready->1, done->1 for one cycle.
//     - uart_tx stays 1.
//   Back-to-back:
//     - With req held high, the next message is accepted in the first IDLE cycle.
//     - The line is therefore high for CLK_CYCLES+1 cycles between messages.
//   Timing:
//     - No gap between bytes inside a message; STOP is followed directly by the next START.
//     - Message duration from accept edge to the ready rise = 10*CLK_CYCLES*2^MSG_LOG_WIDTH cycles.
//   Simultaneous events: done=1 and acceptance of a new req can occur in the same cycle.
//   No X on outputs after reset; uart_tx is driven only from a flop.
// TESTING
//   Default parameters unless stated otherwise.
//   1. Reset: rst_n=0 -> ready=1, done=0, uart_tx=1.
//      Release reset, req=0 for 1000 cycles -> outputs unchanged.
//   2. CLK_CYCLES=4, MSG_LOG_WIDTH=1, data=16'hA55A, one req pulse
//      -> uart_tx = 0,0,1,0,1,1,0,1,0,1 then 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
//      -> ready low 80 cycles; done pulses once.
//   3. CLK_CYCLES=4, MSG_LOG_WIDTH=1, req held high, data=16'h00FF
//      -> two identical messages; line high for exactly 5 cycles between them.
//      -> done and the second accept occur in the same cycle.
//   4. Defaults, 512-bit message whose byte i = i, looped through the multibyte UART receiver
//      -> receiver data equals the sent message.
//      -> ready low 55680 cycles.
//   5. Change data and pulse req mid-message -> transmitted bytes unchanged; no second message.
//   6. rst_n=0 in the middle of byte 3 -> uart_tx=1 in the same cycle.
//      -> After release: ready=1; the next req sends a full message from byte 0.

Source files
------------

// File: rtl/uart_msg_serializer.sv
// ---------------------------------------------------------------------------
// uart_msg_serializer
//   Sends one 2**MSG_LOG_WIDTH-byte message over a UART TX line as 8N1
//   frames (start bit, 8 data bits LSB first, stop bit). Byte 0 goes first.
//   Bytes follow each other with no idle gap. A ready/req handshake makes
//   sure no result is dropped while a message is in flight.
//
// Parameters
//   CLK_CYCLES     clock cycles per UART bit (>= 2)
//   MSG_LOG_WIDTH  log2 of the message length in bytes
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   data     message; byte i = data[8*i+7:8*i]. Sampled only on accept.
//   req      request to send data
//   ready    block is idle; a req in this cycle is accepted at the next edge
//   done     one-cycle pulse after the last stop bit
//   uart_tx  serial line, idle high, driven straight from a flop
// ---------------------------------------------------------------------------
module uart_msg_serializer #(
  parameter int CLK_CYCLES    = 87,
  parameter int MSG_LOG_WIDTH = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [8*(2**MSG_LOG_WIDTH)-1:0] data,
  input  logic                            req,
  output logic                            ready,
  output logic                            done,
  output logic                            uart_tx
);

  localparam int                MSG_BITS  = 8 * (2 ** MSG_LOG_WIDTH);
  localparam int                BAUD_W    = $clog2(CLK_CYCLES);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                   state, state_n;
  logic [BAUD_W-1:0]        baud_cnt, baud_n;
  logic [2:0]               bit_idx, bit_n;
  logic [MSG_LOG_WIDTH-1:0] byte_idx, byte_n;
  logic                     tx_n;
  logic                     done_n;
  logic                     load;
  logic                     bit_end;
  logic [2:0]               bit_inc;
  logic [MSG_BITS-1:0]      shadow;

  assign ready   = (state == S_IDLE);
  assign bit_end = (baud_cnt == BAUD_LAST);
  assign bit_inc = bit_idx + 3'd1;

  // Next-state logic. uart_tx is computed one cycle ahead here and then
  // registered, so the line never carries a combinational glitch.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so
    // that no path leaves a signal unassigned, which would infer a latch.
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    tx_n    = uart_tx;
    done_n  = 1'b0;
    load    = 1'b0;

    if (state != S_IDLE) begin
      baud_n = bit_end ? '0 : baud_cnt + 1'b1;
    end

    unique case (state)
      S_IDLE: begin
        if (req) begin
          load    = 1'b1;
          state_n = S_START;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          // bit_idx is always 0 here: it wraps back after data bit 7.
          tx_n    = shadow[{byte_idx, bit_idx}];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_n = bit_inc;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            tx_n = shadow[{byte_idx, bit_inc}];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          // byte_idx wraps to 0 after the last byte, ready for the next message.
          byte_n = byte_idx + 1'b1;
          if (byte_idx == '1) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            tx_n    = 1'b1;
          end else begin
            state_n = S_START;
            tx_n    = 1'b0;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      uart_tx  <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      uart_tx  <= tx_n;
      done     <= done_n;
    end
  end

  // NOTE: the message shadow is a wide datapath register with no reset; it
  // is always loaded on accept before any bit of it reaches the line.
  always_ff @(posedge clk) begin
    if (load) begin
      shadow <= data;
    end
  end

endmodule
